// File: rtl/audio_pwm_out_pkg.sv
// Shared definitions for the audio PWM playout stage.
//   SAMPLE_W            width of one audio sample (two's complement on input)
//   MIDSCALE            offset-binary midpoint; also the idle PWM duty
//   DEFAULT_SAMPLE_DIV  clocks per output sample (100 MHz / 48 kHz)
//   DEFAULT_DEPTH       default FIFO depth
//   PWM_W               PWM counter / duty width
package audio_pwm_out_pkg;

  localparam int SAMPLE_W           = 8;
  localparam int PWM_W              = 8;
  localparam int DEFAULT_SAMPLE_DIV = 2083;
  localparam int DEFAULT_DEPTH      = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t MIDSCALE = 8'h80;

  // Attenuate a signed sample by an arithmetic right shift, then flip the
  // sign bit to turn two's complement into offset binary for the PWM duty.
  function automatic sample_t to_offset(input sample_t s, input logic [2:0] vol);
    logic signed [SAMPLE_W-1:0] sh;
    sh = $signed(s) >>> vol;
    return sample_t'(sh) ^ MIDSCALE;
  endfunction

endpackage

// File: rtl/audio_pwm_out_sync_fifo.sv
// Single-clock FIFO buffering filtered samples ahead of playout.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   push, wdata       write request and data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   rdata             head entry, valid whenever empty is low
//   full, empty       occupancy flags
//   count             occupancy 0..DEPTH
module sync_fifo
  import audio_pwm_out_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = SAMPLE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO still accepts a write in the same cycle a read frees a slot.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; resetting the pointers discards the contents.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio playout stage: buffers filtered samples and plays them out at a fixed
// sample rate as an 8-bit PWM stream.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   sample_in      filtered sample, two's complement
//   sample_valid   one-cycle strobe qualifying sample_in
//   volume         attenuation shift 0..7, applied when a sample is popped
//   sample_tick    one-cycle pulse per output sample period
//   pwm_out        registered PWM output
//   fifo_count     FIFO occupancy 0..DEPTH
//   overflow       sticky: a sample was dropped because the FIFO was full
//   underflow      sticky: a sample period elapsed with the FIFO empty
module audio_pwm_out
  import audio_pwm_out_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_W-1:0]     sample_in,
  input  logic                    sample_valid,
  input  logic [2:0]              volume,
  output logic                    sample_tick,
  output logic                    pwm_out,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sample_tick_q, sample_tick_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  sample_t          cur_sample_q, cur_sample_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             pwm_out_q, pwm_out_d;

  logic             tick;
  sample_t          fifo_rdata;
  logic             fifo_full, fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (sample_valid),
    .pop   (tick),
    .wdata (sample_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    tick          = (div_cnt_q == DIV_LAST);
    div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
    sample_tick_d = tick;

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    overflow_d  = overflow_q | (sample_valid & fifo_full & ~tick);
    underflow_d = underflow_q | (tick & fifo_empty);

    cur_sample_d = cur_sample_q;
    if (tick && !fifo_empty) cur_sample_d = to_offset(fifo_rdata, volume);

    // Duty only follows cur_sample at the frame boundary so a frame is never
    // split between two duty values.
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    duty_d    = (pwm_cnt_q == '1) ? cur_sample_q : duty_q;
    pwm_out_d = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q     <= '0;
      sample_tick_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      cur_sample_q  <= MIDSCALE;
      pwm_cnt_q     <= '0;
      duty_q        <= MIDSCALE;
      pwm_out_q     <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      sample_tick_q <= sample_tick_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      cur_sample_q  <= cur_sample_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      pwm_out_q     <= pwm_out_d;
    end
  end

  assign sample_tick = sample_tick_q;
  assign pwm_out     = pwm_out_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
